bus_master_arbiter: RTL and testbench
=====================================

// Module: bus_master_arbiter
// PURPOSE
//  Parametrised successor to the XT hold/DMA arbiter: arbitrates N_MASTERS bus requesters against
//  the 8088, syncs HOLD/HLDA to cpu_clock edges, honours LOCK, drives address_enable_n and
//  per-master grants, builds the 20-bit bus address from per-channel page registers.
//  Sits between the DMA/bus-master agents and the 8288 command path.
// PARAMETERS
//  N_MASTERS        4   requester count (1..8)
//  PAGE_WIDTH       4   page register width (upper address bits)
//  LOW_WIDTH        16  channel-supplied low address bits
//  MAX_GRANT_CYCLES 64  cpu_clock posedges allowed per grant (timeout feature only)
// PORTS
//  clock            in  1    system clock; all logic on posedge
//  reset_n          in  1    asynchronous, active-low reset
//  cpu_clock        in  1    8088 clock, sampled as data; edges detected internally
//  processor_status in  3    8088 S2..S0
//  processor_lock_n in  1    8088 LOCK#
//  request          in  N    per-master bus request, active high, level
//  priority_rotate  in  1    0 = fixed (index 0 highest), 1 = rotating
//  grant_n          out N    per-master grant, active low, one-hot-or-none
//  hold_acknowledge out 1    bus granted away from CPU
//  address_enable_n out 1    1 = CPU address/command drivers off
//  master_wait_n    out 1    low while bus is handed over / returned
//  page_write       in  1    1-clock strobe: page_reg[page_select] <= page_data
//  page_select      in  3    page register index
//  page_data        in  PAGE_WIDTH
//  channel_address  in  LOW_WIDTH   low address from active master
//  bus_address      out PAGE_WIDTH+LOW_WIDTH  {page_reg[winner], channel_address} when granted, else 0
//  timeout_event    out 1    1-clock pulse on forced release (tied 0 without macro)
// BEHAVIOUR
//  - Reset: grant_n all 1, hold_acknowledge 0, address_enable_n 0, master_wait_n 1, bus_address 0,
//    timeout_event 0, page regs 0, rotate pointer 0, prev cpu_clock 0, state IDLE. Takes effect
//    immediately, including mid-grant.
//  - cpu_pos = ~prev & cpu_clock, cpu_neg = prev & ~cpu_clock (prev registered each clock).
//  - FSM (transitions on clock, gated by the cpu edge named):
//    IDLE: |request -> REQ.
//    REQ: cpu_pos with S1:S0==2'b11, lock_n==1 -> SYNC; request==0 -> IDLE.
//    SYNC: cpu_neg -> GRANT; latch winner, hold_acknowledge<=1, master_wait_n<=0; request==0 -> IDLE.
//    GRANT: cpu_pos -> address_enable_n<=1 -> HANDOVER.
//    HANDOVER: cpu_pos -> grant_n[winner]<=0, master_wait_n<=1 -> ACTIVE.
//    ACTIVE: request[winner]==0 -> RELEASE (grant_n all 1, hold_acknowledge 0, master_wait_n 0).
//    RELEASE: cpu_pos -> address_enable_n<=0, master_wait_n<=1 -> IDLE.
//  - Winner fixed from SYNC to RELEASE; other requests ignored until IDLE. Winner recomputed at
//    SYNC exit from current request vector.
//  - Fixed: lowest set index wins. Rotating: search from (ptr) upward mod N; on RELEASE
//    ptr <= winner+1 mod N. priority_rotate sampled at winner latch.
//  - Page write same clock as use: bus_address shows old value that clock, new next.
//    page_select >= N_MASTERS: write ignored.
//  - bus_address combinational from page_reg[winner], channel_address, only in ACTIVE.
// CONFIGURATION
//  BUS_MASTER_ARBITER_TIMEOUT_EN defined: counter of cpu_pos in ACTIVE; at MAX_GRANT_CYCLES
//   force RELEASE, pulse timeout_event, mask that master until its request drops.
//  Undefined: grant held indefinitely; timeout_event constant 0; no counter logic.
// TESTING
//  1 fixed: request=4'b0110, status 3'b111, lock_n=1 -> grant_n=4'b1101; hold_ack at cpu_neg after
//    qualifying cpu_pos; address_enable_n 1 next cpu_pos; grant one cpu_pos later.
//  2 rotating: request=4'b1111 held, each winner drops once served -> grant order 0,1,2,3,0.
//  3 lock: lock_n=0 with request=4'b0001 -> stays REQ, hold_ack 0; lock_n=1 -> grant proceeds.
//  4 page: page_write sel=2 data=4'hA, winner 2, channel_address=16'h1234 -> bus_address=20'hA1234.
//  5 timeout (macro, MAX=8): request[0] held -> release after 8 cpu_pos, 1 timeout pulse, no regrant to 0 until it drops.
//  6 reset_n low in ACTIVE -> all outputs at reset values same clock; resumes from IDLE.

Source files
------------

// File: rtl/bus_master_arbiter_if.sv
// Bus-master handshake bundle: requests/grants, CPU-side bus control and the composed address.
// master = DMA/bus-master agent side, slave = arbiter side.
interface bus_master_arbiter_if #(
    parameter int unsigned N_MASTERS  = 4,
    parameter int unsigned PAGE_WIDTH = 4,
    parameter int unsigned LOW_WIDTH  = 16
);
    logic [N_MASTERS-1:0]            request;
    logic [N_MASTERS-1:0]            grant_n;
    logic                            hold_acknowledge;
    logic                            address_enable_n;
    logic                            master_wait_n;
    logic [LOW_WIDTH-1:0]            channel_address;
    logic [PAGE_WIDTH+LOW_WIDTH-1:0] bus_address;
    logic                            timeout_event;

    modport master (
        output request,
        output channel_address,
        input  grant_n,
        input  hold_acknowledge,
        input  address_enable_n,
        input  master_wait_n,
        input  bus_address,
        input  timeout_event
    );

    modport slave (
        input  request,
        input  channel_address,
        output grant_n,
        output hold_acknowledge,
        output address_enable_n,
        output master_wait_n,
        output bus_address,
        output timeout_event
    );
endinterface

// File: rtl/bus_master_arbiter.sv
// Hold/DMA arbiter: hands the 8088 bus to one of N_MASTERS requesters in step with cpu_clock edges.
// Optional grant timeout enabled by defining BUS_MASTER_ARBITER_TIMEOUT_EN.
module bus_master_arbiter #(
    parameter int unsigned N_MASTERS        = 4,
    parameter int unsigned PAGE_WIDTH       = 4,
    parameter int unsigned LOW_WIDTH        = 16,
    parameter int unsigned MAX_GRANT_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_clock,
    input  logic [2:0]            processor_status,
    input  logic                  processor_lock_n,
    input  logic                  priority_rotate,
    input  logic                  page_write,
    input  logic [2:0]            page_select,
    input  logic [PAGE_WIDTH-1:0] page_data,
    bus_master_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SYNC,
        GRANT,
        HANDOVER,
        ACTIVE,
        RELEASE
    } state_t;

    state_t                 state, state_d;
    logic                   prev_cpu;
    logic                   cpu_pos, cpu_neg;
    logic [IDX_W-1:0]       winner, winner_d;
    logic [IDX_W-1:0]       rot_ptr, rot_ptr_d;
    logic [IDX_W-1:0]       win_c, ptr_next_c;
    logic                   win_found;
    logic [N_MASTERS-1:0]   grant_n, grant_n_d;
    logic [N_MASTERS-1:0]   req_eff;
    logic                   hold_ack, hold_ack_d;
    logic                   aen_n, aen_n_d;
    logic                   mwait_n, mwait_n_d;
    logic                   release_c;
    logic [PAGE_WIDTH-1:0]  page_reg [N_MASTERS];
    logic                   unused_status_s2;

    // S2 is not needed to recognise the passive (S1:S0 = 11) bus state
    assign unused_status_s2 = processor_status[2];

    assign cpu_pos = ~prev_cpu & cpu_clock;
    assign cpu_neg = prev_cpu & ~cpu_clock;

`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_GRANT_CYCLES + 1);

    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [N_MASTERS-1:0] mask, mask_d;
    logic                 tmo, tmo_d;

    // a timed-out master stays masked until it lets go of its request
    assign req_eff           = bus.request & ~mask;
    assign bus.timeout_event = tmo;
`else
    assign req_eff           = bus.request;
    assign bus.timeout_event = 1'b0;
`endif

    // first requester at or above the start index, wrapping mod N_MASTERS
    always_comb begin : winner_select
        int unsigned base;
        int unsigned cand;
        base      = priority_rotate ? 32'(rot_ptr) : 32'd0;
        cand      = 32'd0;
        win_c     = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            cand = base + i;
            if (cand >= N_MASTERS) begin
                cand = cand - N_MASTERS;
            end
            if (!win_found && req_eff[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_c     = IDX_W'(cand);
            end
        end
    end

    assign ptr_next_c = (winner == IDX_W'(N_MASTERS - 1)) ? '0 : winner + IDX_W'(1);

    always_comb begin : fsm_next
        state_d    = state;
        winner_d   = winner;
        rot_ptr_d  = rot_ptr;
        grant_n_d  = grant_n;
        hold_ack_d = hold_ack;
        aen_n_d    = aen_n;
        mwait_n_d  = mwait_n;
        release_c  = 1'b0;
`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
        cnt_d      = cnt;
        mask_d     = mask & bus.request;
        tmo_d      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req_eff) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!(|req_eff)) begin
                    state_d = IDLE;
                end else if (cpu_pos && (processor_status[1:0] == 2'b11) && processor_lock_n) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (!(|req_eff)) begin
                    state_d = IDLE;
                end else if (cpu_neg) begin
                    state_d    = GRANT;
                    winner_d   = win_c;
                    hold_ack_d = 1'b1;
                    mwait_n_d  = 1'b0;
                end
            end
            GRANT: begin
                if (cpu_pos) begin
                    state_d = HANDOVER;
                    aen_n_d = 1'b1;
                end
            end
            HANDOVER: begin
                if (cpu_pos) begin
                    state_d   = ACTIVE;
                    grant_n_d = ~(N_MASTERS'(1) << winner);
                    mwait_n_d = 1'b1;
`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ACTIVE: begin
                release_c = ~bus.request[winner];
`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
                if (!release_c && cpu_pos) begin
                    if (cnt == CNT_W'(MAX_GRANT_CYCLES - 1)) begin
                        release_c      = 1'b1;
                        tmo_d          = 1'b1;
                        mask_d[winner] = 1'b1;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
`endif
                if (release_c) begin
                    state_d    = RELEASE;
                    grant_n_d  = '1;
                    hold_ack_d = 1'b0;
                    mwait_n_d  = 1'b0;
                    rot_ptr_d  = ptr_next_c;
                end
            end
            RELEASE: begin
                if (cpu_pos) begin
                    state_d   = IDLE;
                    aen_n_d   = 1'b0;
                    mwait_n_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            prev_cpu <= 1'b0;
            winner   <= '0;
            rot_ptr  <= '0;
            grant_n  <= '1;
            hold_ack <= 1'b0;
            aen_n    <= 1'b0;
            mwait_n  <= 1'b1;
        end else begin
            state    <= state_d;
            prev_cpu <= cpu_clock;
            winner   <= winner_d;
            rot_ptr  <= rot_ptr_d;
            grant_n  <= grant_n_d;
            hold_ack <= hold_ack_d;
            aen_n    <= aen_n_d;
            mwait_n  <= mwait_n_d;
        end
    end

`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            mask <= '0;
            tmo  <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            mask <= mask_d;
            tmo  <= tmo_d;
        end
    end
`endif

    // out-of-range selects are dropped rather than aliased onto a real channel
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                page_reg[i] <= '0;
            end
        end else if (page_write && (32'(page_select) < N_MASTERS)) begin
            page_reg[page_select[IDX_W-1:0]] <= page_data;
        end
    end

    assign bus.grant_n          = grant_n;
    assign bus.hold_acknowledge = hold_ack;
    assign bus.address_enable_n = aen_n;
    assign bus.master_wait_n    = mwait_n;
    assign bus.bus_address      = (state == ACTIVE) ? {page_reg[winner], bus.channel_address} : '0;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: fixed/rotating priority, LOCK, page registers, reset, timeout.
module tb_bus_master_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 4;
    localparam int unsigned LW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cpu_clock;
    logic [2:0]    processor_status;
    logic          processor_lock_n;
    logic          priority_rotate;
    logic          page_write;
    logic [2:0]    page_select;
    logic [PW-1:0] page_data;

    int n_checks   = 0;
    int n_errors   = 0;
    int tmo_pulses = 0;

    bus_master_arbiter_if #(.N_MASTERS(N), .PAGE_WIDTH(PW), .LOW_WIDTH(LW)) bus ();

    bus_master_arbiter #(
        .N_MASTERS(N), .PAGE_WIDTH(PW), .LOW_WIDTH(LW), .MAX_GRANT_CYCLES(8)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cpu_clock        (cpu_clock),
        .processor_status (processor_status),
        .processor_lock_n (processor_lock_n),
        .priority_rotate  (priority_rotate),
        .page_write       (page_write),
        .page_select      (page_select),
        .page_data        (page_data),
        .bus              (bus)
    );

    always #5 clock = ~clock;

    // cpu_clock period is 8 system clocks, changed away from the sampling edge
    initial begin
        cpu_clock = 1'b0;
        forever begin
            repeat (4) @(negedge clock);
            cpu_clock = ~cpu_clock;
        end
    end

    always @(negedge clock) begin
        if (bus.timeout_event === 1'b1) tmo_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset_n         = 1'b0;
        bus.request     = '0;
        bus.channel_address = '0;
        page_write      = 1'b0;
        page_select     = '0;
        page_data       = '0;
        priority_rotate = 1'b0;
        processor_status = 3'b111;
        processor_lock_n = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (bus.grant_n === 4'hF && n < 200) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.address_enable_n !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
    endtask

    // wait for a grant, compare it, then drop the winner and follow the bus back to the CPU
    task automatic serve(input string tag, input logic [N-1:0] exp_gn);
        int n;
        wait_grant(n);
        check(tag, bus.grant_n, exp_gn);
        bus.request = bus.request & bus.grant_n;
        @(negedge clock);
        check({tag, "_rel"}, {bus.hold_acknowledge, bus.address_enable_n, bus.master_wait_n, bus.grant_n},
              7'b0101111);
        wait_idle(n);
        check({tag, "_idle"}, {bus.address_enable_n, bus.master_wait_n, bus.hold_acknowledge}, 3'b010);
    endtask

    initial begin
        int n;
        int p0;
        logic [N-1:0] rot_exp [5];
        rot_exp[0] = 4'b1110;
        rot_exp[1] = 4'b1101;
        rot_exp[2] = 4'b1011;
        rot_exp[3] = 4'b0111;
        rot_exp[4] = 4'b1110;

        // reset state
        apply_reset();
        check("rst_grant_n", bus.grant_n, 4'hF);
        check("rst_ctrl", {bus.hold_acknowledge, bus.address_enable_n, bus.master_wait_n}, 3'b001);
        check("rst_bus_address", bus.bus_address, 20'h0);
        check("rst_timeout", bus.timeout_event, 1'b0);

        // 1: fixed priority handover sequence
        bus.channel_address = 16'hBEEF;
        bus.request = 4'b0110;
        n = 0;
        while (bus.hold_acknowledge !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("t1_hold", bus.hold_acknowledge, 1'b1);
        check("t1_hold_ctrl", {bus.address_enable_n, bus.master_wait_n, bus.grant_n}, 6'b00_1111);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.address_enable_n !== 1'b1 && n < 50);
        check("t1_aen_delay", n, 4);
        check("t1_aen_ctrl", {bus.hold_acknowledge, bus.master_wait_n, bus.grant_n}, 6'b10_1111);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.grant_n === 4'hF && n < 50);
        check("t1_grant_delay", n, 8);
        check("t1_grant_n", bus.grant_n, 4'b1101);
        check("t1_active_ctrl", {bus.hold_acknowledge, bus.address_enable_n, bus.master_wait_n}, 3'b111);
        check("t1_bus_address", bus.bus_address, 20'h0BEEF);
        bus.request = 4'b0100;
        @(negedge clock);
        check("t1_rel", {bus.hold_acknowledge, bus.address_enable_n, bus.master_wait_n, bus.grant_n},
              7'b0101111);
        wait_idle(n);
        serve("t1_second", 4'b1011);

        // 2: rotating priority, all requesting, each winner re-requests after release
        apply_reset();
        priority_rotate = 1'b1;
        bus.request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve($sformatf("t2_rot%0d", k), rot_exp[k]);
            bus.request = 4'b1111;
        end
        bus.request = '0;

        // 3: LOCK holds off the handover
        apply_reset();
        processor_lock_n = 1'b0;
        bus.request = 4'b0001;
        repeat (40) @(negedge clock);
        check("t3_locked", {bus.hold_acknowledge, bus.address_enable_n, bus.grant_n}, 6'b00_1111);
        processor_lock_n = 1'b1;
        serve("t3_grant", 4'b1110);

        // 4: page registers build the upper address bits
        apply_reset();
        page_write  = 1'b1;
        page_select = 3'd2;
        page_data   = 4'hA;
        @(negedge clock);
        page_select = 3'd5;
        page_data   = 4'hF;
        @(negedge clock);
        page_write  = 1'b0;
        bus.channel_address = 16'h1234;
        bus.request = 4'b0100;
        wait_grant(n);
        check("t4_grant_n", bus.grant_n, 4'b1011);
        check("t4_addr", bus.bus_address, 20'hA1234);
        page_write  = 1'b1;
        page_select = 3'd2;
        page_data   = 4'h3;
        #1;
        check("t4_addr_old_page", bus.bus_address, 20'hA1234);
        @(negedge clock);
        page_write = 1'b0;
        check("t4_addr_new_page", bus.bus_address, 20'h31234);
        bus.channel_address = 16'h00FF;
        #1;
        check("t4_addr_chan", bus.bus_address, 20'h300FF);
        bus.request = '0;
        @(negedge clock);
        check("t4_addr_release", bus.bus_address, 20'h0);
        wait_idle(n);
        bus.channel_address = 16'h0055;
        bus.request = 4'b0010;
        wait_grant(n);
        check("t4_grant1", bus.grant_n, 4'b1101);
        check("t4_addr_page1", bus.bus_address, 20'h00055);
        bus.request = '0;
        wait_idle(n);

`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
        // 5: forced release after 8 cpu rising edges, master masked until it drops
        apply_reset();
        p0 = tmo_pulses;
        bus.request = 4'b0001;
        wait_grant(n);
        check("t5_grant", bus.grant_n, 4'b1110);
        n = 0;
        while (bus.grant_n !== 4'hF && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("t5_hold_time", n, 64);
        repeat (60) @(negedge clock);
        check("t5_pulses", tmo_pulses - p0, 1);
        check("t5_masked", {bus.hold_acknowledge, bus.grant_n}, 5'b0_1111);
        bus.request = '0;
        repeat (2) @(negedge clock);
        bus.request = 4'b0001;
        serve("t5_regrant", 4'b1110);
`endif

        // 6: reset mid-grant clears outputs at once and arbitration restarts
        apply_reset();
        bus.request = 4'b0001;
        wait_grant(n);
        check("t6_grant", bus.grant_n, 4'b1110);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {bus.grant_n, bus.hold_acknowledge, bus.address_enable_n, bus.master_wait_n},
              7'b1111_001);
        check("t6_rst_addr", bus.bus_address, 20'h0);
        check("t6_rst_tmo", bus.timeout_event, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        serve("t6_regrant", 4'b1110);

`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
        check("tmo_total", tmo_pulses, 1);
`else
        check("tmo_total", tmo_pulses, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
